// File: rtl/song_sequencer.sv
// song_sequencer: walks song ROM entries {song, index}, hands each note to the note player,
// and waits for note_done before fetching the next entry.
module song_sequencer #(
  parameter int IDX_W  = 5,
  parameter int SONG_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    play,
  input  logic [SONG_W-1:0]       song,
  input  logic                    new_song,
  input  logic                    note_done,
  output logic [SONG_W+IDX_W-1:0] rom_addr,
  input  logic [11:0]             rom_dout,
  output logic                    load_new_note,
  output logic [5:0]              note_to_load,
  output logic [5:0]              duration_to_load,
  output logic                    song_done,
  output logic [IDX_W-1:0]        note_index
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_ROM, LOAD, WAIT_DONE, ADVANCE} state_t;
  state_t                    state_q;
  logic [IDX_W-1:0]          idx_q;
  logic [SONG_W+IDX_W-1:0]   addr_q;
  logic [5:0]                note_q, dur_q;
  logic                      load_q, done_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      note_q  <= '0;
      dur_q   <= '0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      load_q <= 1'b0;
      done_q <= 1'b0;
      if (new_song) begin
        idx_q   <= '0;
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (play) begin
            addr_q  <= {song, idx_q};
            state_q <= FETCH;
          end
          FETCH: state_q <= WAIT_ROM;
          WAIT_ROM: if (rom_dout[5:0] == 6'd0) begin
            done_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= IDLE;
          end else begin
            note_q  <= rom_dout[11:6];
            dur_q   <= rom_dout[5:0];
            load_q  <= 1'b1;
            state_q <= LOAD;
          end
          LOAD: state_q <= WAIT_DONE;
          WAIT_DONE: if (note_done) state_q <= ADVANCE;
          ADVANCE: if (&idx_q) begin
            // last slot of the song: finish instead of spilling into the next song
            done_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= IDLE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= play ? FETCH : IDLE;
            if (play) addr_q <= {song, idx_q + 1'b1};
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign rom_addr         = addr_q;
  assign load_new_note    = load_q;
  assign note_to_load     = note_q;
  assign duration_to_load = dur_q;
  assign song_done        = done_q;
  assign note_index       = idx_q;
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed checks of song_sequencer against a small behavioural song ROM.
module tb_song_sequencer;
  logic        clk = 1'b0;
  logic        reset, play, new_song, note_done;
  logic [1:0]  song;
  logic [6:0]  rom_addr;
  logic [11:0] rom_dout = '0;
  logic        load_new_note, song_done;
  logic [5:0]  note_to_load, duration_to_load;
  logic [4:0]  note_index;
  logic [11:0] rom [0:127];
  int          n_cmp = 0, n_err = 0;
  logic        mon_en = 1'b0, bad_addr = 1'b0;
  int          seen;

  song_sequencer dut (
    .clk(clk), .reset(reset), .play(play), .song(song), .new_song(new_song),
    .note_done(note_done), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .load_new_note(load_new_note), .note_to_load(note_to_load),
    .duration_to_load(duration_to_load), .song_done(song_done), .note_index(note_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_dout <= rom[rom_addr];
  always @(negedge clk) if (mon_en && rom_addr == 7'h60) bad_addr <= 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_load(input string tag);
    for (int i = 0; i < 12; i++) begin
      step();
      if (load_new_note) break;
    end
    chk(tag, load_new_note, 1);
  endtask

  task automatic finish_note();
    step();
    note_done = 1'b1;
    step();
    note_done = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = '0;
    rom[7'h20] = {6'd12, 6'd4};
    rom[7'h21] = {6'd14, 6'd2};
    for (int i = 0; i < 32; i++) begin
      rom[64 + i] = {6'(i + 1), 6'(i + 1)};
      rom[96 + i] = {6'(i + 2), 6'd5};
    end
    reset = 1'b0; play = 1'b0; song = 2'd0; new_song = 1'b0; note_done = 1'b0;
    step();
    step();
    chk("rst_addr", rom_addr, 0);
    chk("rst_load", load_new_note, 0);
    chk("rst_note", note_to_load, 0);
    chk("rst_dur", duration_to_load, 0);
    chk("rst_done", song_done, 0);
    chk("rst_index", note_index, 0);
    // first song: two notes then end marker
    reset = 1'b1; play = 1'b1; song = 2'd1;
    step();
    chk("s1_addr0", rom_addr, 7'h20);
    chk("s1_noload_k", load_new_note, 0);
    step();
    chk("s1_noload_k1", load_new_note, 0);
    step();
    chk("s1_load0", load_new_note, 1);
    chk("s1_note0", note_to_load, 12);
    chk("s1_dur0", duration_to_load, 4);
    step();
    chk("s1_load0_pulse", load_new_note, 0);
    chk("s1_note0_hold", note_to_load, 12);
    note_done = 1'b1;
    step();
    note_done = 1'b0;
    step();
    chk("s1_addr1", rom_addr, 7'h21);
    chk("s1_index1", note_index, 1);
    step();
    chk("s1_noload_gap", load_new_note, 0);
    step();
    chk("s1_load1", load_new_note, 1);
    chk("s1_note1", note_to_load, 14);
    chk("s1_dur1", duration_to_load, 2);
    finish_note();
    step();
    chk("s1_addr2", rom_addr, 7'h22);
    play = 1'b0;
    step();
    chk("s1_done_early", song_done, 0);
    step();
    chk("s1_done", song_done, 1);
    chk("s1_done_noload", load_new_note, 0);
    chk("s1_done_index", note_index, 0);
    step();
    chk("s1_done_pulse", song_done, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (load_new_note) seen++;
    end
    chk("s1_idle_noload", seen, 0);
    // full 32-entry song must end without touching the next song
    song = 2'd2; play = 1'b1; mon_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wait_load("s2_load");
      chk("s2_note", note_to_load, i + 1);
      step();
      note_done = 1'b1;
      if (i == 31) play = 1'b0;
      step();
      note_done = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      if (song_done) break;
      step();
    end
    chk("s2_done", song_done, 1);
    chk("s2_index_wrap", note_index, 0);
    chk("s2_last_addr", rom_addr, 7'h5f);
    step();
    chk("s2_done_pulse", song_done, 0);
    mon_en = 1'b0;
    chk("s2_no_next_song", bad_addr, 0);
    // pause while a note is playing at index 3
    song = 2'd3; play = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_load("s3_load");
      finish_note();
    end
    wait_load("s3_load3");
    chk("s3_index3", note_index, 3);
    step();
    play = 1'b0;
    note_done = 1'b1;
    step();
    note_done = 1'b0;
    step();
    step();
    step();
    chk("pause_index", note_index, 4);
    chk("pause_addr", rom_addr, 7'h63);
    chk("pause_noload", load_new_note, 0);
    play = 1'b1;
    step();
    chk("resume_addr", rom_addr, 7'h64);
    for (int i = 4; i < 7; i++) begin
      wait_load("s3_load_b");
      finish_note();
    end
    wait_load("s3_load7");
    chk("s3_index7", note_index, 7);
    chk("s3_note7", note_to_load, 9);
    step();
    note_done = 1'b1;
    new_song = 1'b1;
    step();
    note_done = 1'b0;
    new_song = 1'b0;
    chk("ns_index", note_index, 0);
    chk("ns_no_done", song_done, 0);
    chk("ns_noload", load_new_note, 0);
    step();
    chk("ns_refetch", rom_addr, 7'h60);
    chk("ns_no_done2", song_done, 0);
    // asynchronous reset while in LOAD
    wait_load("ar_load");
    #2 reset = 1'b0;
    #1;
    chk("ar_load", load_new_note, 0);
    chk("ar_addr", rom_addr, 0);
    chk("ar_note", note_to_load, 0);
    chk("ar_dur", duration_to_load, 0);
    chk("ar_index", note_index, 0);
    chk("ar_done", song_done, 0);
    play = 1'b0;
    step();
    reset = 1'b1;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Sequences a stored song into the note player: fetches (note, duration) entries from a synchronous song ROM, pulses `load_new_note` with the entry, then waits for `note_done` before fetching the next entry.
- Sits between the top-level play/song-select controls and the note player.
- Signals the end of a song with a one-cycle `song_done` pulse.

Parameters:
- IDX_W, 5, note index width; a song holds up to 2^IDX_W entries.
- SONG_W, 2, song select width; the ROM holds 2^SONG_W songs.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- play  input  1  level; 1 = sequence the song, 0 = pause.
- song  input  SONG_W  song select; sampled on every fetch.
- new_song  input  1  one-cycle pulse: abort the current song and restart at index 0.
- note_done  input  1  one-cycle pulse from the note player when the current note has expired.
- rom_addr  output  SONG_W+IDX_W  song ROM address {song, index}, registered.
- rom_dout  input  12  ROM data: [11:6] note, [5:0] duration; valid one cycle after `rom_addr`.
- load_new_note  output  1  one-cycle pulse; `note_to_load`/`duration_to_load` are valid in the same cycle.
- note_to_load  output  6  note number for the note player.
- duration_to_load  output  6  duration in beats.
- song_done  output  1  one-cycle pulse at the end of a song.
- note_index  output  IDX_W  index of the current entry (debug/display).

Behaviour:
- Reset (`reset`=0, asynchronous):
  - State IDLE.
  - index=0.
  - All outputs 0, including `rom_addr`, `note_to_load`, `duration_to_load`, `load_new_note`, `song_done`, `note_index`.
- All outputs are registered; no combinational path from input to output.
- States: IDLE, FETCH, WAIT_ROM, LOAD, WAIT_DONE, ADVANCE.
- IDLE: if `play`=1 -> FETCH, and `rom_addr`<={`song`, index} on that edge. Otherwise stay.
- FETCH: -> WAIT_ROM unconditionally (covers the one-cycle ROM latency).
- WAIT_ROM: `rom_dout` is valid in this cycle.
  - If `rom_dout`[5:0]==0 (end marker): `song_done`<=1, index<=0, -> IDLE.
  - Else: `note_to_load`<=`rom_dout`[11:6], `duration_to_load`<=`rom_dout`[5:0], `load_new_note`<=1, -> LOAD.
- LOAD: `load_new_note` is high for exactly this cycle; -> WAIT_DONE, and `load_new_note`<=0.
- WAIT_DONE: hold `note_to_load`/`duration_to_load` stable. On `note_done`=1 -> ADVANCE.
- ADVANCE:
  - If index==2^IDX_W-1: `song_done`<=1, index<=0, -> IDLE. This handles wrap-around; index never wraps silently into the next song.
  - Else: index<=index+1 and -> IDLE-equivalent fetch. This means -> FETCH if `play`=1, else -> IDLE; `rom_addr` updates with the new index on the FETCH entry.
- Latency: `play` rising sampled at edge k -> `load_new_note` high in the cycle after edge k+2, i.e. 3 cycles.
- Note-to-note gap after `note_done` at edge m: ADVANCE m, FETCH m+1, WAIT_ROM m+2, LOAD after m+3.
- Pause (`play`=0):
  - FETCH, WAIT_ROM, LOAD and WAIT_DONE proceed unchanged. The note player's own `play_enable` freezes timing, so `note_done` will not arrive.
  - Only the ADVANCE->FETCH step is gated by `play`.
  - index is preserved across the pause.
- `new_song`=1 in any state:
  - index<=0, `load_new_note`<=0, -> IDLE.
  - `song_done` is NOT asserted.
  - Has priority over `note_done`, the end marker and `play`.
- `song` changing mid-song without `new_song`: takes effect at the next fetch; index is not reset.
- `note_done` outside WAIT_DONE: ignored.
- `song_done` and `load_new_note` are never high in the same cycle.
- `note_index` always equals the internal index register.

Test Plan:
- Reset then release with `play`=1, `song`=1. ROM entries for song 1: {note 12, dur 4}, {note 14, dur 2}, {dur 0}.
  - `rom_addr`=0x20 one edge after release.
  - `load_new_note` pulse 3 cycles after `play` is sampled, carrying `note_to_load`=12, `duration_to_load`=4.
- Continue the first scenario: pulse `note_done`.
  - `rom_addr`=0x21, then a `load_new_note` pulse with 14/2, 4 cycles after `note_done`.
  - Second `note_done` -> end marker -> one-cycle `song_done` pulse.
  - State returns to IDLE with `note_index`=0 and no further loads.
- Song of 32 non-zero entries (IDX_W=5): after the 32nd `note_done`, `song_done` pulses, `note_index` returns to 0, and `rom_addr` never shows index 0 of the next song.
- `play`=0 while in WAIT_DONE at index 3, then `note_done`.
  - Block waits in IDLE with `note_index`=4.
  - `play`=1 -> fetch of `rom_addr`={song,4}.
- `new_song` pulse at the same cycle as `note_done` at index 7:
  - Next state IDLE, `note_index`=0, no `song_done`.
  - With `play`=1, the next `rom_addr` is {song,0}.
- Assert `reset`=0 asynchronously mid-LOAD: `load_new_note` and all outputs go to 0 immediately, without waiting for a clock edge.
